// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the transmitter (and the receiver).
package uart_pkg;

    // Widest data word any UART block in this slice supports.
    localparam int MAX_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Encoding 2'b11 is not a member and behaves as PAR_NONE.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    // Parity bit over a zero-extended data word; zero padding never changes the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_ext.sv
// Parametrised UART transmitter: valid/ready input with a one-entry holding
// register, optional even/odd parity, 1 or 2 stop bits, fully registered outputs.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [CNT_W-1:0]      tick_cnt, tick_cnt_next;
    logic [IDX_W-1:0]      bit_idx, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid, hold_valid_next;
    logic                  par_en, par_en_next;
    logic                  par_val, par_val_next;
    logic                  stop2_cfg, stop2_cfg_next;
    logic                  stop_second, stop_second_next;
    logic                  tx_next, busy_next, tx_done_next;
    logic                  accept, load, period_end;

    // The holding register is the only thing gating new beats, not the FSM.
    assign s_ready    = ~hold_valid;
    assign accept     = s_valid && s_ready;
    assign period_end = tick && (tick_cnt == CNT_LAST);

    // Capture the offered word into the holding register on accept.
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: hold_data is qualified by hold_valid, so its reset only keeps X out of simulation.
        if (!arst_n) begin
            hold_data <= '0;
        end else if (accept) begin
            hold_data <= s_data;
        end
    end

    // Next-state, datapath and next-output decode for the frame FSM.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_next       = state;
        tick_cnt_next    = tick_cnt;
        bit_idx_next     = bit_idx;
        shift_next       = shift_reg;
        par_en_next      = par_en;
        par_val_next     = par_val;
        stop2_cfg_next   = stop2_cfg;
        stop_second_next = stop_second;
        tx_done_next     = 1'b0;
        load             = 1'b0;

        // Bit-period timing; ticks in IDLE are ignored, the counter restarts at each bit boundary.
        if (state != IDLE && tick) begin
            tick_cnt_next = period_end ? '0 : tick_cnt + CNT_W'(1);
        end

        case (state)
            IDLE:   load = hold_valid;
            START:  if (period_end) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
            DATA:   if (period_end) begin
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state_next = par_en ? PARITY : STOP;
                        end
                    end
            PARITY: if (period_end) begin
                        state_next = STOP;
                    end
            STOP:   if (period_end) begin
                        if (stop2_cfg && !stop_second) begin
                            stop_second_next = 1'b1;
                        end else begin
                            tx_done_next = 1'b1;
                            state_next   = IDLE;
                            load         = hold_valid;
                        end
                    end
            default: state_next = IDLE;
        endcase

        // Frame load: line configuration is frozen here for the whole frame.
        if (load) begin
            state_next       = START;
            tick_cnt_next    = '0;
            bit_idx_next     = '0;
            shift_next       = hold_data;
            par_en_next      = parity_enabled(parity_mode);
            par_val_next     = calc_parity(MAX_DATA_WIDTH'(hold_data), parity_mode == PAR_ODD);
            stop2_cfg_next   = stop2;
            stop_second_next = 1'b0;
        end

        // Accept and unload never coincide because s_ready is low while full.
        hold_valid_next = hold_valid;
        if (accept) begin
            hold_valid_next = 1'b1;
        end else if (load) begin
            hold_valid_next = 1'b0;
        end

        // Line level is decoded from the next state so tx comes straight from a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_val_next;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, as hardware does.
        if (!arst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            hold_valid  <= 1'b0;
            par_en      <= 1'b0;
            par_val     <= 1'b0;
            stop2_cfg   <= 1'b0;
            stop_second <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state       <= state_next;
            tick_cnt    <= tick_cnt_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_next;
            hold_valid  <= hold_valid_next;
            par_en      <= par_en_next;
            par_val     <= par_val_next;
            stop2_cfg   <= stop2_cfg_next;
            stop_second <= stop_second_next;
            tx          <= tx_next;
            busy        <= busy_next;
            tx_done     <= tx_done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed bench for uart_tx_ext (DATA_WIDTH=8, OVERSAMPLE=16): frame shapes,
// parity, stop bits, back-to-back handshake, async reset and slow tick.
module tb_uart_tx_ext;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       tick;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int failures = 0;
    int accepts = 0;
    int cyc = 0;
    int tick_div = 1;
    logic [7:0] pending[$];

    uart_tx_ext #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .tick(tick),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .parity_mode(parity_mode),
        .stop2(stop2),
        .tx(tx),
        .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Tick pattern advances on the falling edge so it is stable at every rising edge.
    always @(negedge clk) cyc <= cyc + 1;
    assign tick = ((cyc % tick_div) == 0);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one cycle and sample just after the falling edge; feed the next pending word on accept.
    task automatic step_drive();
        bit acc;
        acc = s_valid && s_ready;
        @(negedge clk);
        #1;
        if (acc) begin
            accepts++;
            if (pending.size() > 0) s_data = pending.pop_front();
            else s_valid = 1'b0;
        end
    endtask

    // Offer one word while idle; returns at the sample right after the load edge.
    task automatic send_word(input logic [7:0] d);
        int guard;
        guard = 0;
        while (s_ready !== 1'b1 && guard < 1000) begin
            step_drive();
            guard++;
        end
        s_data  = d;
        s_valid = 1'b1;
        step_drive();
        step_drive();
    endtask

    // Record tx from the current sample (first cycle after load) until tx_done and compare bit by bit.
    task automatic capture_check(input string name, input logic [7:0] d, input logic [1:0] pm,
                                 input logic st2, input int per_bit, input int change_at,
                                 input logic [1:0] change_pm, input bit expect_next);
        logic levels[$];
        logic wave[$];
        int   n;
        int   limit;
        bit   done;
        bit   busy_low;
        bit   bad;
        levels.push_back(1'b0);
        for (int i = 0; i < 8; i++) levels.push_back(d[i]);
        if (pm == 2'b01) levels.push_back(^d);
        else if (pm == 2'b10) levels.push_back(~^d);
        levels.push_back(1'b1);
        if (st2) levels.push_back(1'b1);
        limit = (levels.size() + 2) * per_bit + 8;
        n = 0;
        done = 0;
        busy_low = 0;
        while (n < limit) begin
            if (n > 0 && tx_done === 1'b1) begin
                done = 1;
                break;
            end
            wave.push_back(tx);
            if (busy !== 1'b1) busy_low = 1;
            if (n == change_at) parity_mode = change_pm;
            n++;
            step_drive();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s done_timeout: no tx_done after %0d cycles, expected within %0d", name, n, limit);
        end
        checks++;
        if (wave.size() != levels.size() * per_bit) begin
            failures++;
            $display("FAIL %s length: %0d cycles, expected %0d", name, wave.size(), levels.size() * per_bit);
        end
        checks++;
        if (busy_low) begin
            failures++;
            $display("FAIL %s busy: busy=0 inside frame, expected 1", name);
        end
        for (int b = 0; b < levels.size(); b++) begin
            bad = 0;
            for (int c = b * per_bit; c < (b + 1) * per_bit; c++) begin
                if (c >= wave.size()) bad = 1;
                else if (wave[c] !== levels[b]) bad = 1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s bit%0d: tx level not constant %b over cycles %0d..%0d", name, b, levels[b],
                         b * per_bit, (b + 1) * per_bit - 1);
            end
        end
        checks++;
        if (expect_next) begin
            if (busy !== 1'b1 || tx !== 1'b0) begin
                failures++;
                $display("FAIL %s next_start: busy=%b tx=%b, expected busy=1 tx=0", name, busy, tx);
            end
        end else begin
            if (busy !== 1'b0 || tx !== 1'b1) begin
                failures++;
                $display("FAIL %s end_idle: busy=%b tx=%b, expected busy=0 tx=1", name, busy, tx);
            end
        end
    endtask

    // One isolated frame followed by a tx_done pulse-width check.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] pm, input logic st2);
        parity_mode = pm;
        stop2 = st2;
        send_word(d);
        capture_check(name, d, pm, st2, 16, -1, 2'b00, 1'b0);
        step_drive();
        checks++;
        if (tx_done !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: tx_done=%b one cycle later, expected 0", name, tx_done);
        end
    endtask

    task automatic test_reset();
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: tx=%b busy=%b tx_done=%b s_ready=%b, expected 1 0 0 1",
                     tx, busy, tx_done, s_ready);
        end
        repeat (3) step_drive();
        arst_n = 1'b1;
        repeat (20) step_drive();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ticks: tx=%b busy=%b s_ready=%b, expected 1 0 1", tx, busy, s_ready);
        end
    endtask

    task automatic test_basic();
        run_frame("a5_none", 8'hA5, 2'b00, 1'b0);
        run_frame("a5_mode11", 8'hA5, 2'b11, 1'b0);
    endtask

    task automatic test_parity();
        run_frame("03_even", 8'h03, 2'b01, 1'b0);
        run_frame("03_odd", 8'h03, 2'b10, 1'b0);
        run_frame("07_even", 8'h07, 2'b01, 1'b0);
    endtask

    task automatic test_stop2();
        run_frame("ff_stop2", 8'hFF, 2'b00, 1'b1);
    endtask

    task automatic test_back_to_back();
        parity_mode = 2'b00;
        stop2 = 1'b0;
        accepts = 0;
        pending = '{8'hAA, 8'h0F};
        s_data  = 8'h55;
        s_valid = 1'b1;
        step_drive();
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full: s_ready=%b after first accept, expected 0", s_ready);
        end
        step_drive();
        checks++;
        if (s_ready !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load: s_ready=%b tx=%b after load, expected 1 0", s_ready, tx);
        end
        capture_check("b2b_55", 8'h55, 2'b00, 1'b0, 16, -1, 2'b00, 1'b1);
        checks++;
        if (accepts != 2 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall: accepts=%0d s_ready=%b at frame1 end, expected 2 1", accepts, s_ready);
        end
        capture_check("b2b_aa", 8'hAA, 2'b00, 1'b0, 16, -1, 2'b00, 1'b1);
        capture_check("b2b_0f", 8'h0F, 2'b00, 1'b0, 16, -1, 2'b00, 1'b0);
        checks++;
        if (accepts != 3) begin
            failures++;
            $display("FAIL b2b_accepts: accepts=%0d, expected 3", accepts);
        end
    endtask

    task automatic test_async_reset();
        bit bad;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        send_word(8'h3C);
        s_data  = 8'h99;
        s_valid = 1'b1;
        step_drive();
        repeat (30) step_drive();
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre: busy=%b s_ready=%b mid-frame, expected 1 0", busy, s_ready);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_immediate: tx=%b busy=%b s_ready=%b tx_done=%b, expected 1 0 1 0",
                     tx, busy, s_ready, tx_done);
        end
        repeat (3) step_drive();
        arst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step_drive();
            if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_no_frame: line activity after reset release, expected idle");
        end
    endtask

    task automatic test_slow_tick();
        int guard;
        tick_div = 3;
        stop2 = 1'b0;
        parity_mode = 2'b01;
        guard = 0;
        while (tick !== 1'b1 && guard < 10) begin
            step_drive();
            guard++;
        end
        step_drive();
        step_drive();
        s_data  = 8'h03;
        s_valid = 1'b1;
        step_drive();
        step_drive();
        capture_check("slow_03_even", 8'h03, 2'b01, 1'b0, 48, 100, 2'b10, 1'b0);
        tick_div = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_async_reset();
        test_slow_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
